// File: rtl/stages_definition_pkg.sv
// Shared types and constants for the fetch/decode boundary.
// Imported by the fetch stage and its PC unit.
package stages_definition_pkg;

  localparam int N = 32;

  typedef enum logic {
    RUN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [N-1:0] inst;
    logic [N-1:0] r15;
    logic         valid;
  } fetch_deco_interface;

  localparam logic [N-1:0] NOP_INST   = 32'h0000_0000;
  localparam logic [N-1:0] HALT_INST  = 32'hFFFF_FFFF;
  localparam logic [N-1:0] PC_STEP    = 32'd4;
  localparam logic [N-1:0] R15_OFFSET = 32'd8;

  function automatic fetch_deco_interface fd_bubble();
    fetch_deco_interface b;
    b.inst  = NOP_INST;
    b.r15   = '0;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter register with reset/branch/hold/increment
// next-PC selection.
module fetch_pc_unit
  import stages_definition_pkg::*;
#(
  parameter logic [N-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         branch_en_i,
  input  logic [N-1:0] branch_target_i,
  input  logic         hold_i,
  output logic [N-1:0] pc_o
);

  logic [N-1:0] pc_q;
  logic [N-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (branch_en_i) begin
      pc_d = {branch_target_i[N-1:2], 2'b00};
    end else if (!hold_i) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, F/D pipeline register, halt FSM
// and accepted-instruction counter.
module fetch_stage
  import stages_definition_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_en,
  input  logic [N-1:0] branch_target,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] imem_addr,
  output logic [N-1:0] inst_d,
  output logic [N-1:0] r15_d,
  output logic         valid_d,
  output logic         halted,
  output logic [31:0]  fetch_count
);

  fetch_state_t        state_q, state_d;
  fetch_deco_interface fd_q, fd_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [N-1:0]        pc_f;
  logic                is_halt;
  logic                run_fetch;
  logic                pc_hold;

  assign is_halt   = (imem_rdata == HALT_INST);
  assign run_fetch = (state_q == RUN) && !stall && !branch_en;
  // A fetched halt word parks the PC on itself.
  assign pc_hold   = stall || (state_q == HALT)
                  || (run_fetch && is_halt);

  fetch_pc_unit #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk            (clk),
    .rst            (rst),
    .branch_en_i    (branch_en),
    .branch_target_i(branch_target),
    .hold_i         (pc_hold),
    .pc_o           (pc_f)
  );

  always_comb begin
    state_d = state_q;
    fd_d    = fd_q;
    cnt_d   = cnt_q;
    if (branch_en) begin
      fd_d    = fd_bubble();
      state_d = RUN;
    end else if (stall) begin
      fd_d    = fd_q;
    end else if (state_q == HALT) begin
      fd_d    = fd_bubble();
    end else begin
      fd_d.inst  = imem_rdata;
      fd_d.r15   = pc_f + R15_OFFSET;
      fd_d.valid = 1'b1;
      cnt_d      = cnt_q + 32'd1;
      if (is_halt) begin
        state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fd_q    <= fd_bubble();
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fd_q    <= fd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_f;
  assign inst_d      = fd_q.inst;
  assign r15_d       = fd_q.r15;
  assign valid_d     = fd_q.valid;
  assign halted      = (state_q == HALT);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Vector-table bench for fetch_stage with an expected-result
// queue and a fixed instruction-memory image.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_en;
  logic [31:0] branch_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] inst_d;
  logic [31:0] r15_d;
  logic        valid_d;
  logic        halted;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .N(32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_en    (branch_en),
    .branch_target(branch_target),
    .imem_rdata   (imem_rdata),
    .imem_addr    (imem_addr),
    .inst_d       (inst_d),
    .r15_d        (r15_d),
    .valid_d      (valid_d),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    case (a)
      32'h00:  rd = 32'h11;
      32'h04:  rd = 32'h22;
      32'h08:  rd = 32'h33;
      32'h0C:  rd = 32'h44;
      32'h20:  rd = 32'hFFFF_FFFF;
      default: rd = {8'hA5, a[23:0]};
    endcase
  endfunction

  assign imem_rdata = rd(imem_addr);

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] r15;
    logic        valid;
    logic        halted;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(
    input logic rs, input logic st, input logic br,
    input logic [31:0] tgt, input logic [31:0] addr,
    input logic [31:0] inst, input logic [31:0] r15,
    input logic v, input logic h, input logic [31:0] cnt);
    vec_t r;
    r.rst = rs; r.stall = st; r.br = br; r.tgt = tgt;
    r.addr = addr; r.inst = inst; r.r15 = r15;
    r.valid = v; r.halted = h; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    rst           = v.rst;
    stall         = v.stall;
    branch_en     = v.br;
    branch_target = v.tgt;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard step %0d: queue empty", idx);
    end else begin
      e = exp_q.pop_front();
      chk("imem_addr", idx, imem_addr, e.addr);
      chk("inst_d", idx, inst_d, e.inst);
      chk("valid_d", idx, {31'd0, valid_d}, {31'd0, e.valid});
      chk("halted", idx, {31'd0, halted}, {31'd0, e.halted});
      chk("fetch_count", idx, fetch_count, e.cnt);
      if (e.valid || e.rst) chk("r15_d", idx, r15_d, e.r15);
    end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    branch_en = 1'b0;
    branch_target = '0;

    // reset, then four straight-line fetches
    tbl.push_back(mk(1,0,0,0, 32'h00,32'h00,32'h00,0,0,0));
    tbl.push_back(mk(0,0,0,0, 32'h04,32'h11,32'h08,1,0,1));
    tbl.push_back(mk(0,0,0,0, 32'h08,32'h22,32'h0C,1,0,2));
    tbl.push_back(mk(0,0,0,0, 32'h0C,32'h33,32'h10,1,0,3));
    tbl.push_back(mk(0,0,0,0, 32'h10,32'h44,32'h14,1,0,4));
    // three-cycle stall at 0x10, then resume once
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,0,0, 32'h10,32'h44,32'h14,1,0,4));
    tbl.push_back(mk(0,0,0,0, 32'h14,32'hA500_0010,32'h18,1,0,5));
    // branch overrides stall, low bits dropped
    tbl.push_back(mk(0,1,1,32'h103, 32'h100,0,0,0,0,5));
    tbl.push_back(mk(0,0,0,0, 32'h104,32'hA500_0100,32'h108,1,0,6));
    // halt at 0x20 then wrong-path exit by branch
    tbl.push_back(mk(0,0,1,32'h1C, 32'h1C,0,0,0,0,6));
    tbl.push_back(mk(0,0,0,0, 32'h20,32'hA500_001C,32'h24,1,0,7));
    tbl.push_back(mk(0,0,0,0, 32'h20,32'hFFFF_FFFF,32'h28,1,1,8));
    tbl.push_back(mk(0,0,0,0, 32'h20,0,0,0,1,8));
    tbl.push_back(mk(0,0,0,0, 32'h20,0,0,0,1,8));
    tbl.push_back(mk(0,0,1,32'h40, 32'h40,0,0,0,0,8));
    tbl.push_back(mk(0,0,0,0, 32'h44,32'hA500_0040,32'h48,1,0,9));

    foreach (tbl[i]) step(tbl[i], i);

    // PC and R15 wrap at the top of the address space
    step(mk(0,0,1,32'hFFFF_FFFE, 32'hFFFF_FFFC,0,0,0,0,9), 100);
    step(mk(0,0,0,0, 32'h0,32'hA5FF_FFFC,32'h4,1,0,10), 101);

    // reach HALT with count 7, stall there, then reset mid-stall
    step(mk(1,0,0,0, 32'h0,0,0,0,0,0), 200);
    step(mk(0,0,1,32'h8, 32'h8,0,0,0,0,0), 201);
    step(mk(0,0,0,0, 32'h0C,32'h33,32'h10,1,0,1), 202);
    step(mk(0,0,0,0, 32'h10,32'h44,32'h14,1,0,2), 203);
    step(mk(0,0,0,0, 32'h14,32'hA500_0010,32'h18,1,0,3), 204);
    step(mk(0,0,0,0, 32'h18,32'hA500_0014,32'h1C,1,0,4), 205);
    step(mk(0,0,0,0, 32'h1C,32'hA500_0018,32'h20,1,0,5), 206);
    step(mk(0,0,0,0, 32'h20,32'hA500_001C,32'h24,1,0,6), 207);
    step(mk(0,0,0,0, 32'h20,32'hFFFF_FFFF,32'h28,1,1,7), 208);
    step(mk(0,1,0,0, 32'h20,32'hFFFF_FFFF,32'h28,1,1,7), 209);
    step(mk(1,1,0,0, 32'h0,0,0,0,0,0), 210);
    step(mk(0,0,0,0, 32'h4,32'h11,32'h8,1,0,1), 211);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
